// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer capture path: the per-slot byte
// layout used by the frame writer and the ring-buffer read-FSM encoding.
package lpc_sniffer_pkg;

    localparam int OFF_TYPE      = 0;
    localparam int OFF_ADDR3     = 1;
    localparam int OFF_ADDR2     = 2;
    localparam int OFF_ADDR1     = 3;
    localparam int OFF_ADDR0     = 4;
    localparam int OFF_DATA      = 5;
    localparam int SLOT_BYTES    = 8;
    localparam int BYTE_IDX_BITS = $clog2(SLOT_BYTES);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_FETCH   = 2'd1,
        RD_LOAD    = 2'd2,
        RD_PRESENT = 2'd3
    } rd_state_e;

    // True when idx addresses the final streamed byte of a frame.
    function automatic logic is_last_byte(
        input logic [BYTE_IDX_BITS-1:0] idx,
        input int                       frame_bytes
    );
        return (idx == BYTE_IDX_BITS'(frame_bytes - 1));
    endfunction

endpackage

// File: rtl/lpc_slot_counter.sv
// Head/tail/occupancy bookkeeping for the capture slot ring. Pushes while
// full and pops while empty are ignored; both may land in the same clock.
module lpc_slot_counter #(
    parameter int SLOT_BITS = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic [SLOT_BITS-1:0] head,
    output logic [SLOT_BITS-1:0] tail,
    output logic [SLOT_BITS:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [SLOT_BITS:0]   SLOTS    = {1'b1, {SLOT_BITS{1'b0}}};
    localparam logic [SLOT_BITS:0]   CNT_ZERO = {(SLOT_BITS+1){1'b0}};
    localparam logic [SLOT_BITS:0]   CNT_ONE  = (SLOT_BITS+1)'(1);
    localparam logic [SLOT_BITS-1:0] PTR_ZERO = {SLOT_BITS{1'b0}};
    localparam logic [SLOT_BITS-1:0] PTR_ONE  = SLOT_BITS'(1);

    logic [SLOT_BITS-1:0] head_r;
    logic [SLOT_BITS-1:0] tail_r;
    logic [SLOT_BITS:0]   count_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Full/empty are judged on the pre-update count, so a push arriving while
    // full is dropped even if a pop retires a slot in the same clock.
    assign full_s    = (count_r == SLOTS);
    assign empty_s   = (count_r == CNT_ZERO);
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Pointer and occupancy registers; pointers wrap naturally at the slot count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = head_r;
    assign tail  = tail_r;
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/lpc_ringbuf_ctrl.sv
// Capture ring-buffer controller: hands the frame writer its next slot,
// counts completed frames and streams stored frames byte-by-byte downstream.
module lpc_ringbuf_ctrl
    import lpc_sniffer_pkg::*;
#(
    parameter int SLOT_BITS   = 5,
    parameter int FRAME_BYTES = 6
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               wr_frame_done,
    output logic [SLOT_BITS-1:0]               wr_target_addr,
    output logic                               wr_enable,
    output logic [SLOT_BITS+BYTE_IDX_BITS-1:0] ram_rd_addr,
    input  logic [7:0]                         ram_rd_data,
    output logic [7:0]                         out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_sof,
    output logic [SLOT_BITS:0]                 fill_level,
    output logic                               overflow,
    input  logic                               overflow_clr
);

    localparam int ADDR_BITS = SLOT_BITS + BYTE_IDX_BITS;
    localparam logic [BYTE_IDX_BITS-1:0] IDX_ZERO = BYTE_IDX_BITS'(0);
    localparam logic [BYTE_IDX_BITS-1:0] IDX_ONE  = BYTE_IDX_BITS'(1);
    localparam logic [BYTE_IDX_BITS-1:0] IDX_SOF  = BYTE_IDX_BITS'(OFF_TYPE);

    logic                     done_q_r;
    logic                     push_r;
    logic                     overflow_r;
    logic                     overflow_next_s;
    rd_state_e                state_r;
    rd_state_e                state_next_s;
    logic [BYTE_IDX_BITS-1:0] byte_idx_r;
    logic [BYTE_IDX_BITS-1:0] byte_idx_next_s;
    logic [ADDR_BITS-1:0]     rd_addr_r;
    logic [ADDR_BITS-1:0]     rd_addr_next_s;
    logic [7:0]               out_data_r;
    logic [7:0]               out_data_next_s;
    logic                     out_valid_r;
    logic                     out_valid_next_s;
    logic                     out_sof_r;
    logic                     out_sof_next_s;
    logic                     pop_s;
    logic [SLOT_BITS-1:0]     head_s;
    logic [SLOT_BITS-1:0]     tail_s;
    logic [SLOT_BITS:0]       count_s;
    logic                     full_s;
    logic                     empty_s;

    lpc_slot_counter #(
        .SLOT_BITS (SLOT_BITS)
    ) u_slots (
        .clock (clock),
        .reset (reset),
        .push  (push_r),
        .pop   (pop_s),
        .head  (head_s),
        .tail  (tail_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sticky overflow; a clear wins over a set landing in the same clock.
    always_comb begin
        overflow_next_s = overflow_r;
        if (overflow_clr) begin
            overflow_next_s = 1'b0;
        end else if (push_r && full_s) begin
            overflow_next_s = 1'b1;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Frame-done edge detect, registered into a one-clock push strobe. The
    // edge register resets low so a level already high at release counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q_r   <= 1'b0;
            push_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_q_r   <= wr_frame_done;
            push_r     <= wr_frame_done & ~done_q_r;
            overflow_r <= overflow_next_s;
        end
    end

    // Read FSM next-state and datapath: one byte every three clocks at best,
    // with the RAM address held from issue until the byte is accepted.
    always_comb begin
        state_next_s     = state_r;
        byte_idx_next_s  = byte_idx_r;
        rd_addr_next_s   = rd_addr_r;
        out_data_next_s  = out_data_r;
        out_valid_next_s = out_valid_r;
        out_sof_next_s   = out_sof_r;
        pop_s            = 1'b0;
        case (state_r)
            RD_IDLE: begin
                if (!empty_s) begin
                    rd_addr_next_s = {tail_s, byte_idx_r};
                    state_next_s   = RD_FETCH;
                end else begin
                    state_next_s   = RD_IDLE;
                end
            end
            RD_FETCH: begin
                state_next_s = RD_LOAD;
            end
            RD_LOAD: begin
                out_data_next_s  = ram_rd_data;
                out_valid_next_s = 1'b1;
                out_sof_next_s   = (byte_idx_r == IDX_SOF);
                state_next_s     = RD_PRESENT;
            end
            RD_PRESENT: begin
                if (out_ready) begin
                    out_valid_next_s = 1'b0;
                    out_sof_next_s   = 1'b0;
                    if (is_last_byte(byte_idx_r, FRAME_BYTES)) begin
                        byte_idx_next_s = IDX_ZERO;
                        pop_s           = 1'b1;
                        state_next_s    = RD_IDLE;
                    end else begin
                        byte_idx_next_s = byte_idx_r + IDX_ONE;
                        rd_addr_next_s  = {tail_s, byte_idx_next_s};
                        state_next_s    = RD_FETCH;
                    end
                end else begin
                    state_next_s = RD_PRESENT;
                end
            end
            default: begin
                state_next_s = RD_IDLE;
            end
        endcase
    end

    // Read FSM state and registered stream outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= RD_IDLE;
            byte_idx_r  <= IDX_ZERO;
            rd_addr_r   <= {ADDR_BITS{1'b0}};
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            byte_idx_r  <= byte_idx_next_s;
            rd_addr_r   <= rd_addr_next_s;
            out_data_r  <= out_data_next_s;
            out_valid_r <= out_valid_next_s;
            out_sof_r   <= out_sof_next_s;
        end
    end

    assign wr_target_addr = head_s;
    assign wr_enable      = ~full_s;
    assign ram_rd_addr    = rd_addr_r;
    assign out_data       = out_data_r;
    assign out_valid      = out_valid_r;
    assign out_sof        = out_sof_r;
    assign fill_level     = count_s;
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_lpc_ringbuf_ctrl.sv
// Self-checking bench for lpc_ringbuf_ctrl: a RAM model, a queue-of-slots
// reference and a stream monitor that checks every transferred byte.
module tb_lpc_ringbuf_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_frame_done;
    logic [4:0] wr_target_addr;
    logic       wr_enable;
    logic [7:0] ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic [5:0] fill_level;
    logic       overflow;
    logic       overflow_clr;

    logic [7:0] mem [0:255];
    logic [4:0] pushed_slot [0:63];
    int         n_pushed = 0;
    int         n_popped = 0;
    logic [4:0] head_m;
    logic       overflow_m;
    int         tests_run = 0;
    int         failed = 0;

    lpc_ringbuf_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .wr_frame_done  (wr_frame_done),
        .wr_target_addr (wr_target_addr),
        .wr_enable      (wr_enable),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sof        (out_sof),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_rd_data <= mem[ram_rd_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every byte leaving the DUT must be the next byte of the oldest stored
    // slot, read from that slot's address; a stalled byte must not change.
    task automatic monitor();
        int         byte_m = 0;
        bit         pend = 1'b0;
        logic [7:0] pend_data = 8'h00;
        logic       pend_sof = 1'b0;
        logic [4:0] slot;
        logic [7:0] exp_addr;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                n_popped = 0;
                byte_m   = 0;
                pend     = 1'b0;
            end else begin
                if (pend) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out_data !== pend_data || out_sof !== pend_sof) begin
                        failed++;
                        $display("FAIL hold_stable: valid=%b data=%h sof=%b, required valid=1 data=%h sof=%b",
                                 out_valid, out_data, out_sof, pend_data, pend_sof);
                    end
                end
                if (out_valid === 1'b1) begin
                    tests_run++;
                    if (n_popped >= n_pushed) begin
                        failed++;
                        $display("FAIL stream_extra: byte %h presented with no stored frame", out_data);
                    end else begin
                        slot     = pushed_slot[n_popped % 64];
                        exp_addr = {slot, 3'(byte_m)};
                        if (out_data !== mem[exp_addr] || out_sof !== (byte_m == 0) || ram_rd_addr !== exp_addr) begin
                            failed++;
                            $display("FAIL stream_byte: data=%h sof=%b addr=%h, required data=%h sof=%b addr=%h",
                                     out_data, out_sof, ram_rd_addr, mem[exp_addr], (byte_m == 0), exp_addr);
                        end
                    end
                    if (out_ready === 1'b1) begin
                        byte_m++;
                        if (byte_m == 6) begin
                            byte_m = 0;
                            n_popped++;
                        end
                    end
                end
                pend      = (out_valid === 1'b1) && (out_ready !== 1'b1);
                pend_data = out_data;
                pend_sof  = out_sof;
            end
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        wr_frame_done = 1'b0;
        out_ready     = 1'b0;
        overflow_clr  = 1'b0;
        n_pushed      = 0;
        head_m        = 5'd0;
        overflow_m    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_spec_frame();
        mem[8'd0] = 8'h01; mem[8'd1] = 8'hFE; mem[8'd2] = 8'hDC;
        mem[8'd3] = 8'hBA; mem[8'd4] = 8'h98; mem[8'd5] = 8'h42;
    endtask

    // One writer frame: fills the head slot (unless full), pulses done, then
    // checks occupancy, head pointer and overflow against the model.
    task automatic push_frame(input bit rand_data);
        int outstanding;
        outstanding = n_pushed - n_popped;
        tests_run++;
        if (wr_enable !== (outstanding != 32)) begin
            failed++;
            $display("FAIL push_wr_enable: got %b, required %b", wr_enable, (outstanding != 32));
        end
        if (outstanding == 32) begin
            overflow_m = 1'b1;
        end else begin
            if (rand_data) begin
                for (int b = 0; b < 6; b++) mem[{head_m, 3'(b)}] = 8'($urandom);
            end
            pushed_slot[n_pushed % 64] = head_m;
            n_pushed++;
            head_m = head_m + 5'd1;
        end
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        tick();
        tests_run++;
        if (fill_level !== 6'(n_pushed - n_popped) || wr_target_addr !== head_m || overflow !== overflow_m) begin
            failed++;
            $display("FAIL push_state: fill=%0d head=%0d ovf=%b, required fill=%0d head=%0d ovf=%b",
                     fill_level, wr_target_addr, overflow, n_pushed - n_popped, head_m, overflow_m);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
    endtask

    task automatic send_byte();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (fill_level !== 6'd0 && n < bound) begin
            tick();
            n++;
        end
        tests_run++;
        if (fill_level !== 6'd0) begin
            failed++;
            $display("FAIL drain: fill_level=%0d after %0d cycles, required 0", fill_level, n);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        wr_frame_done = 1'b1;
        out_ready     = 1'b0;
        overflow_clr  = 1'b0;
        n_pushed      = 0;
        head_m        = 5'd0;
        overflow_m    = 1'b0;
        for (int b = 0; b < 6; b++) mem[8'(b)] = 8'($urandom);
        tick();
        tick();
        tests_run++;
        if (wr_target_addr !== 5'd0 || wr_enable !== 1'b1 || ram_rd_addr !== 8'd0 || out_data !== 8'd0 ||
            out_valid !== 1'b0 || out_sof !== 1'b0 || fill_level !== 6'd0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL reset_values: head=%0d wen=%b raddr=%h data=%h valid=%b sof=%b fill=%0d ovf=%b, required 0 1 00 00 0 0 0 0",
                     wr_target_addr, wr_enable, ram_rd_addr, out_data, out_valid, out_sof, fill_level, overflow);
        end
        pushed_slot[0] = 5'd0;
        n_pushed       = 1;
        head_m         = 5'd1;
        reset          = 1'b1;
        tick();
        tick();
        tick();
        wr_frame_done = 1'b0;
        tests_run++;
        if (fill_level !== 6'd1 || wr_target_addr !== 5'd1) begin
            failed++;
            $display("FAIL reset_level_edge: fill=%0d head=%0d, required fill=1 head=1", fill_level, wr_target_addr);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        load_spec_frame();
        out_ready = 1'b1;
        push_frame(1'b0);
        wait_empty(100);
        tests_run++;
        if (n_popped !== 1) begin
            failed++;
            $display("FAIL single_frames: streamed %0d frames, required 1", n_popped);
        end
        push_frame(1'b1);
        wait_empty(100);
        tests_run++;
        if (n_popped !== 2) begin
            failed++;
            $display("FAIL single_tail: streamed %0d frames, required 2", n_popped);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_spec_frame();
        push_frame(1'b0);
        for (int b = 0; b < 3; b++) begin
            wait_valid();
            send_byte();
        end
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'hBA || ram_rd_addr !== 8'h03) begin
                failed++;
                $display("FAIL backpressure_hold: valid=%b data=%h addr=%h, required 1 BA 03",
                         out_valid, out_data, ram_rd_addr);
            end
        end
        send_byte();
        wait_valid();
        tests_run++;
        if (out_data !== 8'h98) begin
            failed++;
            $display("FAIL backpressure_next: data=%h, required 98", out_data);
        end
        out_ready = 1'b1;
        wait_empty(100);
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 33; i++) push_frame(1'b1);
        tests_run++;
        if (fill_level !== 6'd32 || wr_enable !== 1'b0 || overflow !== 1'b1 || wr_target_addr !== 5'd0) begin
            failed++;
            $display("FAIL full_state: fill=%0d wen=%b ovf=%b head=%0d, required 32 0 1 0",
                     fill_level, wr_enable, overflow, wr_target_addr);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        overflow_m   = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            failed++;
            $display("FAIL overflow_clr: ovf=%b, required 0", overflow);
        end
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        overflow_clr  = 1'b1;
        tick();
        overflow_clr  = 1'b0;
        tick();
        tests_run++;
        if (overflow !== 1'b0 || fill_level !== 6'd32) begin
            failed++;
            $display("FAIL clr_priority: ovf=%b fill=%0d, required ovf=0 fill=32", overflow, fill_level);
        end
        out_ready = 1'b1;
        wait_empty(2000);
        tests_run++;
        if (n_popped !== 32) begin
            failed++;
            $display("FAIL full_drain: streamed %0d frames, required 32", n_popped);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 20; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            push_frame(1'b0);
        end
        out_ready = 1'b1;
        wait_empty(2000);
        tests_run++;
        if (n_popped !== 40 || wr_target_addr !== 5'd8) begin
            failed++;
            $display("FAIL wrap_total: frames=%0d head=%0d, required frames=40 head=8", n_popped, wr_target_addr);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) push_frame(1'b1);
        for (int b = 0; b < 5; b++) begin
            wait_valid();
            send_byte();
        end
        wait_valid();
        for (int b = 0; b < 6; b++) mem[{head_m, 3'(b)}] = 8'($urandom);
        pushed_slot[n_pushed % 64] = head_m;
        n_pushed++;
        head_m = head_m + 5'd1;
        wr_frame_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_frame_done = 1'b0;
            out_ready     = (i == 0);
            tests_run++;
            if (fill_level !== 6'd5) begin
                failed++;
                $display("FAIL simul_fill: step %0d fill=%0d, required 5", i, fill_level);
            end
        end
        tests_run++;
        if (wr_target_addr !== 5'd6) begin
            failed++;
            $display("FAIL simul_head: head=%0d, required 6", wr_target_addr);
        end
        wait_valid();
        tests_run++;
        if (ram_rd_addr !== 8'h08) begin
            failed++;
            $display("FAIL simul_tail: addr=%h, required 08", ram_rd_addr);
        end
        out_ready = 1'b1;
        wait_empty(400);
    endtask

    task automatic test_async_reset();
        do_reset();
        push_frame(1'b1);
        push_frame(1'b1);
        for (int b = 0; b < 2; b++) begin
            wait_valid();
            send_byte();
        end
        wait_valid();
        #2;
        reset    = 1'b0;
        n_pushed = 0;
        head_m   = 5'd0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || fill_level !== 6'd0 || wr_target_addr !== 5'd0) begin
            failed++;
            $display("FAIL async_reset: valid=%b fill=%0d head=%0d, required 0 0 0", out_valid, fill_level, wr_target_addr);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (out_valid !== 1'b0 || fill_level !== 6'd0 || wr_target_addr !== 5'd0) begin
            failed++;
            $display("FAIL post_reset_push: valid=%b fill=%0d head=%0d, required 0 0 0", out_valid, fill_level, wr_target_addr);
        end
    endtask

    initial begin
        reset         = 1'b0;
        wr_frame_done = 1'b0;
        out_ready     = 1'b0;
        overflow_clr  = 1'b0;
        head_m        = 5'd0;
        overflow_m    = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_backpressure();
        test_full_overflow();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
